aidc_lite_comp_ctrl: RTL and testbench

Block-level controller for the AIDC-Lite ZRLE compression engine. It accepts 512-bit blocks from two requesters and grants them round-robin. It then serialises the granted block into eight contiguous 64-bit beats with SOP/EOP, because the engine has no backpressure. Finally it waits for the engine's completion indication and returns a per-block result (compressed bit size, raw-fallback decision, error) to the requester that owned the block. One block is in flight at a time.

---
 rtl/aidc_lite_pkg.sv | 31 +++
 rtl/aidc_lite_rr_arb2.sv | 34 +++
 rtl/aidc_lite_comp_ctrl.sv | 118 +++++++++++
 tb/tb_aidc_lite_comp_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aidc_lite_pkg.sv
// AIDC-Lite shared definitions.
// Block geometry, controller states and the response bundle.
package aidc_lite_pkg;

  localparam int AIDC_BEATS      = 8;
  localparam int AIDC_BEAT_W     = 64;
  localparam int AIDC_BLK_SIZE_W = 11;
  localparam int AIDC_BLK_W      = AIDC_BEATS * AIDC_BEAT_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } aidc_state_e;

  typedef struct packed {
    logic                       id;
    logic [AIDC_BLK_SIZE_W-1:0] size;
    logic                       raw;
    logic                       err;
  } aidc_rsp_t;

  function automatic logic [AIDC_BEAT_W-1:0] aidc_beat(
    input logic [AIDC_BLK_W-1:0] blk,
    input logic [2:0]            idx
  );
    return blk[idx*AIDC_BEAT_W +: AIDC_BEAT_W];
  endfunction

endpackage

// File: rtl/aidc_lite_rr_arb2.sv
// AIDC-Lite 2-way round-robin arbiter.
// Pointer names the preferred requester; it flips past each grant.
module aidc_lite_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic ptr;

  // pick a requester; contention resolved by the pointer
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        gnt = ptr ? 2'b10 : 2'b01;
      end else begin
        gnt = req;
      end
    end
  end

  // after a grant, prefer the other requester next time
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (|gnt) begin
      ptr <= gnt[0];
    end
  end

endmodule

// File: rtl/aidc_lite_comp_ctrl.sv
// AIDC-Lite compression block controller.
// Grants a block, streams 8 beats, awaits done, returns the result.
module aidc_lite_comp_ctrl
  import aidc_lite_pkg::*;
#(
  parameter int TIMEOUT  = 64,
  parameter int RAW_BITS = 512
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [1:0]                       req_valid_i,
  input  logic [1:0][AIDC_BLK_W-1:0]       req_data_i,
  output logic [1:0]                       req_ready_o,
  output logic                             comp_valid_o,
  output logic                             comp_sop_o,
  output logic                             comp_eop_o,
  output logic [AIDC_BEAT_W-1:0]           comp_data_o,
  input  logic                             comp_done_i,
  input  logic [AIDC_BLK_SIZE_W-1:0]       comp_blk_size_i,
  output logic                             rsp_valid_o,
  input  logic                             rsp_ready_i,
  output logic                             rsp_id_o,
  output logic [AIDC_BLK_SIZE_W-1:0]       rsp_size_o,
  output logic                             rsp_raw_o,
  output logic                             rsp_err_o
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [AIDC_BLK_SIZE_W-1:0] RAW_LIM =
    AIDC_BLK_SIZE_W'(RAW_BITS);

  aidc_state_e           state;
  logic [AIDC_BLK_W-1:0] blk;
  logic                  blk_id;
  logic [2:0]            beat;
  logic [7:0]            tmo;
  aidc_rsp_t             rsp;
  logic [1:0]            gnt;
  logic                  gnt_en;
  logic                  tmo_hit;
  logic                  last_beat;

  assign gnt_en    = rst_n && (state == IDLE);
  assign tmo_hit   = (tmo == TMO_LAST);
  assign last_beat = (beat == 3'd7);

  aidc_lite_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_valid_i),
    .en    (gnt_en),
    .gnt   (gnt)
  );

  assign req_ready_o  = gnt;
  assign comp_valid_o = (state == ISSUE);
  assign comp_sop_o   = comp_valid_o && (beat == 3'd0);
  assign comp_eop_o   = comp_valid_o && last_beat;
  assign comp_data_o  = comp_valid_o ? aidc_beat(blk, beat) : '0;
  assign rsp_valid_o  = (state == RESP);
  assign rsp_id_o     = rsp.id;
  assign rsp_size_o   = rsp.size;
  assign rsp_raw_o    = rsp.raw;
  assign rsp_err_o    = rsp.err;

  // block FSM: capture, stream, wait for done or timeout, hold result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      blk    <= '0;
      blk_id <= 1'b0;
      beat   <= 3'd0;
      tmo    <= 8'd0;
      rsp    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|gnt) begin
            blk    <= gnt[1] ? req_data_i[1] : req_data_i[0];
            blk_id <= gnt[1];
            beat   <= 3'd0;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          beat <= beat + 3'd1;
          if (last_beat) begin
            tmo   <= 8'd0;
            state <= WAIT;
          end
        end
        WAIT: begin
          tmo <= tmo + 8'd1;
          if (comp_done_i) begin
            rsp.id   <= blk_id;
            rsp.size <= comp_blk_size_i;
            rsp.raw  <= (comp_blk_size_i > RAW_LIM);
            rsp.err  <= 1'b0;
            state    <= RESP;
          end else if (tmo_hit) begin
            rsp.id   <= blk_id;
            rsp.size <= '0;
            rsp.raw  <= 1'b1;
            rsp.err  <= 1'b1;
            state    <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aidc_lite_comp_ctrl.sv
// Scoreboard bench for aidc_lite_comp_ctrl.
// Engine is a behavioural stand-in reporting a ZRLE-style size.
`timescale 1ns/1ps
module tb_aidc_lite_comp_ctrl;
  import aidc_lite_pkg::*;

  localparam int TMO  = 64;
  localparam int RAWB = 512;

  typedef struct {
    logic [511:0] data;
    int           d;
    logic [10:0]  eng;
    logic         id;
    logic [10:0]  size;
    logic         raw;
    logic         err;
  } blk_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] req_valid_i = '0;
  logic [1:0][511:0] req_data_i = '0;
  logic [1:0] req_ready_o;
  logic comp_valid_o, comp_sop_o, comp_eop_o;
  logic [63:0] comp_data_o;
  logic comp_done_i = 1'b0;
  logic [10:0] comp_blk_size_i = '0;
  logic rsp_valid_o;
  logic rsp_ready_i = 1'b0;
  logic rsp_id_o;
  logic [10:0] rsp_size_o;
  logic rsp_raw_o, rsp_err_o;

  aidc_lite_comp_ctrl #(.TIMEOUT(TMO), .RAW_BITS(RAWB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o),
    .comp_valid_o(comp_valid_o), .comp_sop_o(comp_sop_o),
    .comp_eop_o(comp_eop_o), .comp_data_o(comp_data_o),
    .comp_done_i(comp_done_i), .comp_blk_size_i(comp_blk_size_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_id_o(rsp_id_o), .rsp_size_o(rsp_size_o),
    .rsp_raw_o(rsp_raw_o), .rsp_err_o(rsp_err_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  blk_t p0[$];
  blk_t p1[$];
  blk_t exp_q[$];
  int   gord[$];

  bit          idle = 1'b1;
  bit          mptr = 1'b0;
  int          beat_start = -100;
  blk_t        cur;
  bit          rsp_pend = 1'b0;
  int          rsp_cyc = 0;
  int          done_at = -1;
  logic [10:0] done_size = '0;
  bit          armed = 1'b0;
  bit          chk_zero = 1'b0;
  bit          want_rst = 1'b1;
  int          rdy_mode = 0;
  bit [1:0]    mute = 2'b00;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic [10:0] zrle_size(input logic [511:0] d);
    int s = 0;
    for (int k = 0; k < 8; k++) s += (d[64*k +: 64] == 64'd0) ? 6 : 66;
    return 11'(s);
  endfunction

  function automatic blk_t mk(input logic r, input logic [511:0] data,
                              input int d, input logic [10:0] eng);
    blk_t b;
    b.data = data;
    b.d    = d;
    b.eng  = eng;
    b.id   = r;
    b.err  = (d >= TMO);
    b.size = b.err ? 11'd0 : eng;
    b.raw  = b.err ? 1'b1 : (int'(eng) > RAWB);
    return b;
  endfunction

  task automatic send(input logic r, input logic [511:0] data,
                      input int d, input logic [10:0] eng);
    if (r) p1.push_back(mk(r, data, d, eng));
    else   p0.push_back(mk(r, data, d, eng));
  endtask

  function automatic logic [511:0] rblk();
    logic [511:0] v;
    for (int k = 0; k < 8; k++)
      v[64*k +: 64] = ($urandom_range(0, 1) == 1) ? 64'd0
                      : {$urandom, $urandom};
    return v;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // input driver and engine stand-in, just after each rising edge
  always @(posedge clk) begin
    #1;
    rst_n = !want_rst;
    req_valid_i[0] = (p0.size() > 0) && !mute[0];
    req_valid_i[1] = (p1.size() > 0) && !mute[1];
    req_data_i[0] = (p0.size() > 0) ? p0[0].data : {16{$urandom}};
    req_data_i[1] = (p1.size() > 0) ? p1[0].data : {16{$urandom}};
    comp_done_i = (cyc == done_at);
    comp_blk_size_i = comp_done_i ? done_size : 11'($urandom);
    case (rdy_mode)
      0:       rsp_ready_i = 1'b1;
      1:       rsp_ready_i = 1'($urandom_range(0, 1));
      default: rsp_ready_i = 1'b0;
    endcase
  end

  // monitor and reference model, on the falling edge
  always @(negedge clk) begin
    int k;
    logic [1:0] eg;
    logic pick;
    logic erv;
    if (armed) begin
      if (chk_zero) begin
        chk("reset_ctl", {req_ready_o, comp_valid_o, comp_sop_o,
            comp_eop_o, rsp_valid_o, rsp_id_o, rsp_size_o, rsp_raw_o,
            rsp_err_o}, 64'd0);
        chk("reset_data", comp_data_o, 64'd0);
        chk_zero = 1'b0;
      end
      eg = 2'b00;
      pick = 1'b0;
      if (rst_n && idle && (req_valid_i != 2'b00)) begin
        pick = (req_valid_i == 2'b11) ? mptr : req_valid_i[1];
        eg = pick ? 2'b10 : 2'b01;
      end
      chk("grant", 64'(req_ready_o), 64'(eg));
      if (eg != 2'b00) begin
        if (pick && p1.size() > 0) cur = p1.pop_front();
        else if (!pick && p0.size() > 0) cur = p0.pop_front();
        exp_q.push_back(cur);
        gord.push_back(int'(pick));
        mptr = !pick;
        idle = 1'b0;
        beat_start = cyc + 1;
      end
      k = cyc - beat_start;
      chk("beat_ctl", {comp_valid_o, comp_sop_o, comp_eop_o},
          {61'd0, (k >= 0 && k < 8), (k == 0), (k == 7)});
      if (k >= 0 && k < 8)
        chk("beat_data", comp_data_o, cur.data[64*k +: 64]);
      if (k == 7) begin
        rsp_pend = 1'b1;
        rsp_cyc = cyc + ((cur.d < TMO) ? 2 + cur.d : 1 + TMO);
        done_at = (cur.d <= TMO + 8) ? cyc + 1 + cur.d : -1;
        done_size = cur.eng;
      end
      erv = rsp_pend && (cyc >= rsp_cyc);
      chk("rsp_valid", 64'(rsp_valid_o), 64'(erv));
      if (erv && exp_q.size() > 0) begin
        chk("rsp_fields",
            {rsp_id_o, rsp_size_o, rsp_raw_o, rsp_err_o},
            {exp_q[0].id, exp_q[0].size, exp_q[0].raw, exp_q[0].err});
        if (rsp_ready_i) begin
          void'(exp_q.pop_front());
          rsp_pend = 1'b0;
          idle = 1'b1;
        end
      end
    end
    if (!rst_n) begin
      armed = 1'b1;
      chk_zero = 1'b1;
      idle = 1'b1;
      mptr = 1'b0;
      beat_start = -100;
      rsp_pend = 1'b0;
      exp_q.delete();
      done_at = -1;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drain(input int lim);
    int n = 0;
    while ((p0.size() > 0 || p1.size() > 0 || exp_q.size() > 0 || !idle)
           && n < lim) begin
      step();
      n++;
    end
    if (n >= lim) begin
      checks++;
      errors++;
      $display("FAIL drain: still busy after %0d cycles", lim);
    end
  endtask

  task automatic wait_grant(input int lim);
    int n = 0;
    while (idle && n < lim) begin
      step();
      n++;
    end
    if (n >= lim) begin
      checks++;
      errors++;
      $display("FAIL wait_grant: no grant within %0d cycles", lim);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [511:0] d;
    int dd, sel;
    logic [10:0] eng;
    logic [10:0] bnd [5];
    bnd[0] = 11'd0;   bnd[1] = 11'd511; bnd[2] = 11'd512;
    bnd[3] = 11'd513; bnd[4] = 11'd2047;

    repeat (3) step();
    want_rst = 1'b0;
    step();

    send(1'b0, '0, 0, zrle_size('0));
    drain(200);
    send(1'b1, '1, 3, zrle_size('1));
    drain(200);

    gord.delete();
    for (int i = 0; i < 2; i++) begin
      d = rblk(); send(1'b0, d, 1, zrle_size(d));
      d = rblk(); send(1'b1, d, 2, zrle_size(d));
    end
    drain(400);
    chk("rr_order", (gord.size() == 4) ?
        {gord[0][3:0], gord[1][3:0], gord[2][3:0], gord[3][3:0]} : 64'hdead,
        64'h0101);

    d = rblk(); send(1'b0, d, TMO + 3, 11'd100);
    d = rblk(); send(1'b1, d, 0, zrle_size(d));
    drain(400);

    rdy_mode = 2;
    d = rblk(); send(1'b0, d, 1, zrle_size(d));
    d = rblk(); send(1'b1, d, 0, zrle_size(d));
    for (int n = 0; n < 100 && !(rsp_pend && cyc >= rsp_cyc); n++) step();
    repeat (20) step();
    rdy_mode = 0;
    drain(400);

    d = rblk(); send(1'b0, d, 0, zrle_size(d));
    wait_grant(50);
    while (cyc + 1 < beat_start + 3) step();
    want_rst = 1'b1;
    step();
    want_rst = 1'b0;
    step();
    gord.delete();
    d = rblk(); send(1'b0, d, 0, zrle_size(d));
    d = rblk(); send(1'b1, d, 0, zrle_size(d));
    drain(300);
    chk("post_reset_order", (gord.size() == 2) ?
        {gord[0][3:0], gord[1][3:0]} : 64'hdead, 64'h01);

    rdy_mode = 1;
    for (int i = 0; i < 40; i++) begin
      d = rblk();
      sel = $urandom_range(0, 9);
      if (sel < 7)      dd = $urandom_range(0, 6);
      else if (sel < 9) dd = $urandom_range(TMO - 2, TMO + 8);
      else              dd = 200;
      if ($urandom_range(0, 3) == 0) eng = bnd[$urandom_range(0, 4)];
      else                           eng = zrle_size(d);
      send(1'($urandom_range(0, 1)), d, dd, eng);
      repeat ($urandom_range(0, 12)) begin
        mute = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
        step();
      end
    end
    mute = 2'b00;
    drain(8000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
